// File: rtl/addsub_slice_sched.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_slice_sched
//  Purpose  : Shares one narrow add-with-carry-in slice adder between two
//             requesters. Each granted request is a WIDTH-bit add or
//             subtract (A + ~B + 1), carried out LSB-first one SLICE-bit
//             slice per cycle. The inter-slice carry is held in a register.
//
//  Ports    : CLK, RESETN          - clock (rising edge), async active-low reset
//             REQ_VALID/REQ_READY  - per-requester handshake (READY one-hot/0)
//             REQ_A, REQ_B         - packed operands, requester i at [i*WIDTH +: WIDTH]
//             REQ_SUB              - per-requester op select (1 = A-B)
//             RSP_VALID/RSP_READY  - result handshake
//             RSP_O, RSP_COUT      - result and final carry (sub: 1 = no borrow)
//             RSP_ID               - requester owning the result
//             RSP_OVF              - signed overflow (only with ADDSUB_SLICE_SCHED_OVF_EN)
//             ALU_I0, ALU_I1, ALU_CIN - slice operands / carry-in to shared adder
//             ALU_O, ALU_COUT      - slice sum / carry-out from shared adder
//
//  Options  : define ADDSUB_SLICE_SCHED_OVF_EN to add the RSP_OVF output.
//
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_slice_sched #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [1:0]           REQ_VALID,
    output logic [1:0]           REQ_READY,
    input  logic [2*WIDTH-1:0]   REQ_A,
    input  logic [2*WIDTH-1:0]   REQ_B,
    input  logic [1:0]           REQ_SUB,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [WIDTH-1:0]     RSP_O,
    output logic                 RSP_COUT,
    output logic                 RSP_ID,
`ifdef ADDSUB_SLICE_SCHED_OVF_EN
    output logic                 RSP_OVF,
`endif
    output logic [SLICE-1:0]     ALU_I0,
    output logic [SLICE-1:0]     ALU_I1,
    output logic                 ALU_CIN,
    input  logic [SLICE-1:0]     ALU_O,
    input  logic                 ALU_COUT
);

    localparam int NSL = WIDTH / SLICE;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic              r_last;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_sub;
    logic              r_id;
    logic [KW-1:0]     r_k;
    logic [WIDTH-1:0]  r_res;
    logic              r_cy;
    logic [WIDTH-1:0]  r_rsp_o;
    logic              r_rsp_cout;
    logic              r_rsp_id;
`ifdef ADDSUB_SLICE_SCHED_OVF_EN
    logic              r_rsp_ovf;
`endif

    logic              w_grant_id;
    logic              w_accept;
    logic [WIDTH-1:0]  w_a_sel;
    logic [WIDTH-1:0]  w_b_sel;
    logic              w_sub_sel;
    logic [WIDTH-1:0]  w_res_next;
    logic              w_last_slice;

    // ------------------------------------------------------------------
    // Arbitration: single requester wins outright; on a tie the one that
    // was not served last wins. READY is forced low while reset is held so
    // the port reads as its reset value even with REQ_VALID asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_id = 1'b0;
        case (REQ_VALID)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_last;
            default: w_grant_id = 1'b0;
        endcase
        w_accept  = RESETN && (r_state == S_IDLE) && (|REQ_VALID);
        REQ_READY = 2'b00;
        if (w_accept) begin
            REQ_READY = w_grant_id ? 2'b10 : 2'b01;
        end
    end

    assign w_a_sel   = w_grant_id ? REQ_A[2*WIDTH-1:WIDTH] : REQ_A[WIDTH-1:0];
    assign w_b_sel   = w_grant_id ? REQ_B[2*WIDTH-1:WIDTH] : REQ_B[WIDTH-1:0];
    assign w_sub_sel = w_grant_id ? REQ_SUB[1] : REQ_SUB[0];

    assign w_last_slice = (r_k == KW'(NSL - 1));

    // ------------------------------------------------------------------
    // Shared slice drive: only active in RUN. The first slice takes the
    // subtract flag as carry-in, which supplies the +1 of A + ~B + 1.
    // ------------------------------------------------------------------
    always_comb begin
        ALU_I0  = '0;
        ALU_I1  = '0;
        ALU_CIN = 1'b0;
        if (r_state == S_RUN) begin
            ALU_I0  = r_a[r_k*SLICE +: SLICE];
            ALU_I1  = r_b[r_k*SLICE +: SLICE];
            ALU_CIN = (r_k == '0) ? r_sub : r_cy;
        end
    end

    // Working result with the current slice merged in; on the final slice
    // this is the complete result and is copied to the response register.
    always_comb begin
        w_res_next = r_res;
        if (r_state == S_RUN) begin
            w_res_next[r_k*SLICE +: SLICE] = ALU_O;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_id       <= 1'b0;
            r_k        <= '0;
            r_res      <= '0;
            r_cy       <= 1'b0;
            r_rsp_o    <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_id   <= 1'b0;
`ifdef ADDSUB_SLICE_SCHED_OVF_EN
            r_rsp_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_a_sel;
                        r_b     <= w_sub_sel ? ~w_b_sel : w_b_sel;
                        r_sub   <= w_sub_sel;
                        r_id    <= w_grant_id;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res <= w_res_next;
                    r_cy  <= ALU_COUT;
                    r_k   <= r_k + KW'(1);
                    if (w_last_slice) begin
                        // Response outputs only change here, so they hold
                        // across the handshake until the next completion.
                        r_rsp_o    <= w_res_next;
                        r_rsp_cout <= ALU_COUT;
                        r_rsp_id   <= r_id;
`ifdef ADDSUB_SLICE_SCHED_OVF_EN
                        r_rsp_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                      (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
`endif
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (RSP_READY) begin
                        r_last  <= r_id;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RSP_VALID = (r_state == S_DONE);
    assign RSP_O     = r_rsp_o;
    assign RSP_COUT  = r_rsp_cout;
    assign RSP_ID    = r_rsp_id;
`ifdef ADDSUB_SLICE_SCHED_OVF_EN
    assign RSP_OVF   = r_rsp_ovf;
`endif

endmodule
`default_nettype wire
